// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - N-channel W-bit registered multiplexer with manual and auto-scan selection
module mux_scan_n #(
   parameter int N     = 4,
   parameter int W     = 1,
   parameter int DWELL = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N*W-1:0]   inf_ul,
   input  logic [((N > 1) ? $clog2(N) : 1)-1:0] adr_ul,
   input  logic             mod_ul,
   input  logic [N-1:0]     maska_ul,
   output logic [W-1:0]     inf_izl,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] adr_izl,
   output logic             vld_izl,
   output logic             wrap_izl
);

   localparam int AW = (N > 1) ? $clog2(N) : 1;
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0] CNT_LAST = DW'(DWELL - 1);

   typedef enum logic [1:0] {st_man, st_scan, st_none} state_t;

   state_t         state;
   logic [DW-1:0]  cnt;
   logic [AW-1:0]  entry_adr;
   logic [AW-1:0]  adv_adr;
   logic           cur_en;
   logic           man_ok;

   // First enabled channel searching upward modulo N, from start itself (incl) or from start+1.
   function automatic logic [AW-1:0] find_next(input logic [AW-1:0] start,
                                               input logic [N-1:0]  m,
                                               input logic          incl);
      int   base;
      int   idx;
      logic found;
      find_next = start;
      found     = 1'b0;
      base      = int'(start) + (incl ? 0 : 1);
      for (int k = 0; k < N; k++) begin
         idx = (base + k) % N;
         if (!found && m[idx]) begin
            find_next = idx[AW-1:0];
            found     = 1'b1;
         end
      end
   endfunction

   function automatic logic [W-1:0] chan_data(input logic [N*W-1:0] d,
                                              input logic [AW-1:0]  a);
      chan_data = '0;
      for (int k = 0; k < N; k++) begin
         if (int'(a) == k) chan_data = d[k*W +: W];
      end
   endfunction

   always_comb begin
      entry_adr = find_next(adr_izl, maska_ul, 1'b1);
      adv_adr   = find_next(adr_izl, maska_ul, 1'b0);
      man_ok    = (int'(adr_ul) < N);
      cur_en    = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (int'(adr_izl) == k) cur_en = maska_ul[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= st_man;
         cnt      <= '0;
         inf_izl  <= '0;
         adr_izl  <= '0;
         vld_izl  <= 1'b0;
         wrap_izl <= 1'b0;
      end else begin
         wrap_izl <= 1'b0;
         if (!mod_ul) begin
            state   <= st_man;
            cnt     <= '0;
            adr_izl <= adr_ul;
            inf_izl <= chan_data(inf_ul, adr_ul);
            vld_izl <= man_ok;
         end else if (maska_ul == '0) begin
            state   <= st_none;
            cnt     <= '0;
            inf_izl <= '0;
            vld_izl <= 1'b0;
         end else if (state != st_scan) begin
            // Entry picks up from the current pointer without a wrap pulse.
            state   <= st_scan;
            cnt     <= '0;
            adr_izl <= entry_adr;
            inf_izl <= chan_data(inf_ul, entry_adr);
            vld_izl <= 1'b1;
         end else if (!cur_en || cnt == CNT_LAST) begin
            cnt      <= '0;
            adr_izl  <= adv_adr;
            inf_izl  <= chan_data(inf_ul, adv_adr);
            vld_izl  <= 1'b1;
            wrap_izl <= (adv_adr <= adr_izl);
         end else begin
            cnt     <= cnt + DW'(1);
            inf_izl <= chan_data(inf_ul, adr_izl);
            vld_izl <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mux_scan_n.sv
// tb/tb_mux_scan_n.sv - directed self-checking bench for mux_scan_n (N=4 DWELL=4 and N=3 DWELL=1)
module tb_mux_scan_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] inf4;
   logic [1:0]  adr4;
   logic        mod4;
   logic [3:0]  mask4;
   logic [3:0]  d4;
   logic [1:0]  a4;
   logic        v4, w4;

   logic [11:0] inf3;
   logic [1:0]  adr3;
   logic        mod3;
   logic [2:0]  mask3;
   logic [3:0]  d3;
   logic [1:0]  a3;
   logic        v3, w3;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] chv4 [4];
   logic [3:0] chv3 [3];
   logic [1:0] ea;

   mux_scan_n #(.N(4), .W(4), .DWELL(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .inf_ul(inf4), .adr_ul(adr4), .mod_ul(mod4),
      .maska_ul(mask4), .inf_izl(d4), .adr_izl(a4), .vld_izl(v4), .wrap_izl(w4));

   mux_scan_n #(.N(3), .W(4), .DWELL(1)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .inf_ul(inf3), .adr_ul(adr3), .mod_ul(mod3),
      .maska_ul(mask3), .inf_izl(d3), .adr_izl(a3), .vld_izl(v3), .wrap_izl(w3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, want, $time);
      end
   endtask

   task automatic chk4(input string tag, input logic [1:0] wa, input logic [3:0] wd,
                       input logic wv, input logic ww);
      chk({tag, ".adr"},  32'(a4), 32'(wa));
      chk({tag, ".data"}, 32'(d4), 32'(wd));
      chk({tag, ".vld"},  32'(v4), 32'(wv));
      chk({tag, ".wrap"}, 32'(w4), 32'(ww));
   endtask

   task automatic chk3(input string tag, input logic [1:0] wa, input logic [3:0] wd,
                       input logic wv, input logic ww);
      chk({tag, ".adr"},  32'(a3), 32'(wa));
      chk({tag, ".data"}, 32'(d3), 32'(wd));
      chk({tag, ".vld"},  32'(v3), 32'(wv));
      chk({tag, ".wrap"}, 32'(w3), 32'(ww));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      chv4 = '{4'h5, 4'hA, 4'h3, 4'hD};
      chv3 = '{4'h7, 4'hC, 4'h9};
      rst_n = 1'b0;
      inf4 = 16'hD3A5; adr4 = 2'd0; mod4 = 1'b0; mask4 = 4'b0000;
      inf3 = 12'h9C7;  adr3 = 2'd0; mod3 = 1'b0; mask3 = 3'b000;

      step(); chk4("rst0", 2'd0, 4'h0, 1'b0, 1'b0);
      step(); chk4("rst1", 2'd0, 4'h0, 1'b0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         adr4 = 2'(i);
         step();
         chk4("man", 2'(i), chv4[i], 1'b1, 1'b0);
      end

      adr4 = 2'd0;
      step(); chk4("man0", 2'd0, 4'h5, 1'b1, 1'b0);

      mod4 = 1'b1; mask4 = 4'b1111;
      for (int i = 0; i < 17; i++) begin
         step();
         ea = 2'((i / 4) % 4);
         chk4("full", ea, chv4[ea], 1'b1, (i == 16));
      end

      mask4 = 4'b1010;
      for (int i = 0; i < 12; i++) begin
         step();
         ea = (((i / 4) % 2) == 1) ? 2'd3 : 2'd1;
         chk4("masked", ea, chv4[ea], 1'b1, (i == 8));
      end

      mask4 = 4'b0100;
      for (int i = 0; i < 9; i++) begin
         step();
         chk4("single", 2'd2, 4'h3, 1'b1, (i == 4 || i == 8));
      end

      mask4 = 4'b0000;
      step(); chk4("none", 2'd2, 4'h0, 1'b0, 1'b0);
      step(); chk4("none_hold", 2'd2, 4'h0, 1'b0, 1'b0);

      mod4 = 1'b0; adr4 = 2'd1;
      step(); chk4("man1", 2'd1, 4'hA, 1'b1, 1'b0);
      mod4 = 1'b1; mask4 = 4'b1110;
      step(); chk4("enter1", 2'd1, 4'hA, 1'b1, 1'b0);
      step(); chk4("dwell1", 2'd1, 4'hA, 1'b1, 1'b0);
      mask4 = 4'b1100;
      for (int i = 0; i < 5; i++) begin
         step();
         ea = (i < 4) ? 2'd2 : 2'd3;
         chk4("drop", ea, chv4[ea], 1'b1, 1'b0);
      end
      step(); chk4("on3", 2'd3, 4'hD, 1'b1, 1'b0);

      rst_n = 1'b0;
      step(); chk4("rst_mid", 2'd0, 4'h0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(); chk4("resume", 2'd2, 4'h3, 1'b1, 1'b0);

      adr3 = 2'd3;
      step(); chk3("n3_oob", 2'd3, 4'h0, 1'b0, 1'b0);
      mod3 = 1'b1; mask3 = 3'b111;
      for (int i = 0; i < 4; i++) begin
         step();
         ea = 2'(i % 3);
         chk3("n3_scan", ea, chv3[ea], 1'b1, (i == 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
